// File: rtl/alu_serial.sv
// alu_serial: bit-serial WIDTH-bit ALU sequencer around a 1-bit slice.
// Ports: clk, rst_n, start, src1, src2, ALU_control in; busy, done,
//        result, zero, cout, overflow out.

module alu_top (
    input  logic       src1,
    input  logic       src2,
    input  logic       less,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout,
    output logic       set
);
    logic a;
    logic b;
    logic sum;

    assign a    = src1 ^ A_invert;
    assign b    = src2 ^ B_invert;
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
    assign set  = sum;

    always_comb begin
        result = 1'b0;
        unique case (operation)
            2'b00: result = a & b;
            2'b01: result = a | b;
            2'b10: result = sum;
            2'b11: result = less;
            default: result = 1'b0;
        endcase
    end
endmodule

module alu_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SLT_FIX = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  opa_q;
    logic [WIDTH-1:0]  opb_q;
    logic [WIDTH-1:0]  sh_q;
    logic [WIDTH-1:0]  result_q;
    logic              ainv_q;
    logic              binv_q;
    logic [1:0]        op_q;
    logic              arith_q;
    logic              slt_q;
    logic              carry_q;
    logic              set_q;
    logic              cpend_q;
    logic              vpend_q;
    logic              zero_q;
    logic              cout_q;
    logic              ovf_q;
    logic              done_q;

    // start decode
    logic              dec_valid_d;
    logic              dec_ainv_d;
    logic              dec_binv_d;
    logic [1:0]        dec_op_d;
    logic              dec_arith_d;
    logic              dec_slt_d;

    always_comb begin
        dec_valid_d = 1'b1;
        dec_ainv_d  = 1'b0;
        dec_binv_d  = 1'b0;
        dec_op_d    = 2'b00;
        dec_arith_d = 1'b0;
        dec_slt_d   = 1'b0;
        unique case (ALU_control)
            4'b0000: dec_op_d = 2'b00;
            4'b0001: dec_op_d = 2'b01;
            4'b0010: begin
                dec_op_d    = 2'b10;
                dec_arith_d = 1'b1;
            end
            4'b0110: begin
                dec_binv_d  = 1'b1;
                dec_op_d    = 2'b10;
                dec_arith_d = 1'b1;
            end
            4'b0111: begin
                dec_binv_d  = 1'b1;
                dec_op_d    = 2'b10;
                dec_arith_d = 1'b1;
                dec_slt_d   = 1'b1;
            end
            4'b1100: begin
                dec_ainv_d = 1'b1;
                dec_binv_d = 1'b1;
            end
            default: dec_valid_d = 1'b0;
        endcase
    end

    logic s_res;
    logic s_cout;
    logic s_set;

    alu_top u_slice (
        .src1      (opa_q[0]),
        .src2      (opb_q[0]),
        .less      (1'b0),
        .A_invert  (ainv_q),
        .B_invert  (binv_q),
        .cin       (carry_q),
        .operation (op_q),
        .result    (s_res),
        .cout      (s_cout),
        .set       (s_set)
    );

    // Final word as seen by the DONE state: SLT already wrote result_q.
    logic [WIDTH-1:0] final_d;
    assign final_d = slt_q ? result_q : sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sh_q     <= '0;
            result_q <= '0;
            ainv_q   <= 1'b0;
            binv_q   <= 1'b0;
            op_q     <= 2'b00;
            arith_q  <= 1'b0;
            slt_q    <= 1'b0;
            carry_q  <= 1'b0;
            set_q    <= 1'b0;
            cpend_q  <= 1'b0;
            vpend_q  <= 1'b0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // The done cycle still counts as busy, so start waits.
                    if (start && !done_q) begin
                        opa_q   <= dec_valid_d ? src1 : '0;
                        opb_q   <= dec_valid_d ? src2 : '0;
                        ainv_q  <= dec_ainv_d;
                        binv_q  <= dec_binv_d;
                        op_q    <= dec_op_d;
                        arith_q <= dec_arith_d;
                        slt_q   <= dec_slt_d;
                        carry_q <= dec_binv_d;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    sh_q    <= {s_res, sh_q[WIDTH-1:1]};
                    carry_q <= s_cout;
                    cnt_q   <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        cpend_q <= s_cout;
                        // carry_q is the carry into the MSB here
                        vpend_q <= carry_q ^ s_cout;
                        set_q   <= s_set;
                        state_q <= slt_q ? SLT_FIX : DONE;
                    end
                end
                SLT_FIX: begin
                    result_q <= {{(WIDTH-1){1'b0}}, set_q ^ vpend_q};
                    state_q  <= DONE;
                end
                DONE: begin
                    result_q <= final_d;
                    zero_q   <= (final_d == '0);
                    cout_q   <= arith_q & cpend_q;
                    ovf_q    <= arith_q & vpend_q;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE) | done_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: randomized self-checking bench for alu_serial.
// Compares against an arithmetic reference model.

module tb_alu_serial;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ALU_control;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int n_cmp;
    int n_bad;

    alu_serial #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [3:0] ctl,
                             output logic [W-1:0] r, output logic c,
                             output logic v);
        logic [W:0]   s;
        logic [W-1:0] d;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        d = a - b;
        case (ctl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110, 4'b0111: begin
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
                if (ctl == 4'b0110) r = d;
                else r = ($signed(a) < $signed(b)) ? 1 : 0;
            end
            default: r = '0;
        endcase
    endtask

    // mode 0: plain, 1: extra start at bit 10, 2: reset at bit 16
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] ctl, input int mode);
        logic [W-1:0] er;
        logic         ec;
        logic         ev;
        logic [W-1:0] prev;
        int           lat;
        int           n;
        bit           seen;
        ref_model(a, b, ctl, er, ec, ev);
        lat = (ctl == 4'b0111) ? W + 2 : W + 1;
        @(negedge clk);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        src1 = a;
        src2 = b;
        ALU_control = ctl;
        @(posedge clk);
        #1;
        start = 1'b0;
        src1 = $urandom;
        src2 = $urandom;
        ALU_control = 4'($urandom);
        prev = result;
        seen = 1'b0;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                chk("latency", 64'(i), 64'(lat));
                seen = 1'b1;
                break;
            end
            chk("busy_run", 64'(busy), 64'd1);
            if (i == 10) chk("hold", 64'(result), 64'(prev));
            if (mode == 1 && i == 10) begin
                start = 1'b1;
                ALU_control = 4'b0010;
            end
            if (mode == 1 && i == 11) start = 1'b0;
            if (mode == 2 && i == 16) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_res", 64'(result), 64'd0);
                chk("rst_zero", 64'(zero), 64'd1);
                chk("rst_flags", {62'd0, cout, overflow}, 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int j = 0; j < W + 6; j++) begin
                    @(posedge clk);
                    #1;
                    chk("rst_nodone", 64'(done), 64'd0);
                end
                return;
            end
        end
        if (!seen) begin
            chk("timeout", 64'd0, 64'd1);
            return;
        end
        chk("result", 64'(result), 64'(er));
        chk("zero", 64'(zero), 64'(er == '0));
        chk("cout", 64'(cout), 64'(ec));
        chk("ovf", 64'(overflow), 64'(ev));
        chk("busy_done", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    logic [3:0] codes [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        src1 = '0;
        src2 = '0;
        ALU_control = '0;
        codes[0] = 4'b0000;
        codes[1] = 4'b0001;
        codes[2] = 4'b0010;
        codes[3] = 4'b0110;
        codes[4] = 4'b0111;
        codes[5] = 4'b1100;
        codes[6] = 4'b0101;
        codes[7] = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_done", 64'(done), 64'd0);
        chk("init_res", 64'(result), 64'd0);
        chk("init_zero", 64'(zero), 64'd1);
        chk("init_flags", {62'd0, cout, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd7, 32'd5, 4'b0010, 0);
        run_op(32'd5, 32'd7, 4'b0110, 0);
        run_op(32'd7, 32'd7, 4'b0110, 0);
        run_op(32'h7FFFFFFF, 32'd1, 4'b0010, 0);
        run_op(32'hFFFFFFFF, 32'd1, 4'b0010, 0);
        run_op(32'h80000000, 32'd1, 4'b0111, 0);
        run_op(32'd5, 32'd3, 4'b0111, 0);
        run_op(32'd3, 32'd5, 4'b0111, 0);
        run_op(32'd0, 32'd0, 4'b1100, 0);
        run_op(32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0000, 0);
        run_op(32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0001, 0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0101, 0);
        run_op(32'h12345678, 32'h0BADF00D, 4'b0110, 1);
        run_op(32'hDEADBEEF, 32'h00000001, 4'b0010, 2);
        run_op(32'd100, 32'd23, 4'b0010, 0);

        for (int t = 0; t < 40; t++) begin
            run_op($urandom, $urandom, codes[$urandom_range(0, 7)], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_serial.md
# alu_serial

Bit-serial WIDTH-bit ALU sequencer that drives a single 1-bit ALU slice (`alu_top`, instantiated internally) one bit per clock. It latches operands and a 4-bit ALU control code, feeds LSB-first bits plus the registered carry into the slice, and collects the slice's result and carry outputs into a word result with zero, carry-out and overflow flags. It sits directly upstream of the slice, in place of a 32-slice ripple array, trading latency for area.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- src1  in  WIDTH  operand A, latched on accepted start
- src2  in  WIDTH  operand B, latched on accepted start
- ALU_control  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; latched on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  final result, held until the next accepted start
- zero  out  1  result == 0, held with result
- cout  out  1  carry out of MSB (ADD/SUB/SLT), else 0
- overflow  out  1  signed overflow (ADD/SUB/SLT), else 0

## Operation
- Decode (at start): AND → A_inv 0, B_inv 0, op 00; OR → 0,0,01; ADD → 0,0,10; SUB/SLT → 0,1,10; NOR → 1,1,00. Carry register initialised to B_inv. Any other code: invalid, slice op 00 with both operands forced to 0 (result 0, flags 0), normal latency.
- Slice wiring: src1 = opA[0], src2 = opB[0], cin = carry register, less tied 0, A_invert/B_invert/operation from decode.
- States: IDLE → RUN (start=1) → SLT_FIX (code SLT) or DONE (other) → IDLE.
- RUN: bit counter 0..WIDTH−1. Each cycle: opA, opB shift right by 1; slice result shifts into the result register at the MSB (after WIDTH shifts bit i lands at position i); carry ← slice cout.
- Last RUN cycle (counter = WIDTH−1): cout ← slice cout; overflow ← carry-in of MSB XOR slice cout; set bit ← slice set.
- SLT_FIX: result ← {WIDTH−1 zeros, set XOR overflow}; cout and overflow keep the subtraction values.
- DONE: done = 1, zero computed from the final result; return to IDLE.
- cout and overflow are forced to 0 for AND/OR/NOR/invalid.
- Arithmetic is modulo 2^WIDTH; SLT is a signed comparison.

## Timing
- Reset (async, rst_n = 0): state IDLE, counter 0, busy 0, done 0, result 0, zero 1, cout 0, overflow 0, operand registers 0. Reset mid-RUN aborts the operation; no done pulse is produced.
- start is accepted on the clk edge with state = IDLE and start = 1. Edge k: accept. Edges k+1..k+WIDTH: RUN bits 0..WIDTH−1. Edge k+WIDTH+1: DONE (or SLT_FIX).
- done is high for exactly one cycle: the cycle following edge k+WIDTH+1 (non-SLT) or k+WIDTH+2 (SLT). WIDTH=32: 33 / 34 cycles after accept.
- busy rises the cycle after accept and falls with the end of the done cycle.
- start while busy is ignored; no queuing. start held high during DONE is not accepted until IDLE is reached, so back-to-back operations have one idle cycle between done and the next accept.
- result/zero/cout/overflow update only at DONE (SLT: at SLT_FIX for result); they are otherwise stable, including during a subsequent RUN.
- src1/src2/ALU_control may change freely after accept.

## Test plan
- ADD 7 + 5 (WIDTH 32) → result 0x0000000C, cout 0, overflow 0, zero 0; done exactly 33 cycles after accept, busy high for 33 cycles.
- SUB 5 − 7 → 0xFFFFFFFE, cout 0, overflow 0; SUB 7 − 7 → 0, zero 1, cout 1.
- ADD 0x7FFFFFFF + 1 → 0x80000000, overflow 1, cout 0; ADD 0xFFFFFFFF + 1 → 0, cout 1, zero 1.
- SLT 0x80000000, 1 → 1 (overflow case); SLT 5, 3 → 0; SLT 3, 5 → 1; done 34 cycles after accept.
- NOR 0, 0 → 0xFFFFFFFF; AND 0xF0F0F0F0, 0x0F0F0F0F → 0, zero 1; OR → 0xFFFFFFFF; invalid code 0101 → 0, done at 33 cycles.
- start pulsed at RUN bit 10 → ignored, result unchanged; rst_n low at RUN bit 16 → all outputs reset immediately, no done pulse, the next start is accepted normally.
